snake_body_ctrl: RTL and testbench

//  Upstream of the apple/stone stage. Owns the snake: direction, move timing, segment list, growth, collisions, game state.

---
 rtl/snake_body_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_snake_body_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/snake_body_ctrl.sv
// Snake body controller: direction, move timing, segment list, growth,
// wall/self collision and IDLE/PLAY/DEAD game state for a walled grid.
module snake_body_ctrl #(
    parameter int unsigned MAX_LEN  = 16,
    parameter int unsigned INIT_LEN = 3,
    parameter int unsigned TICK_DIV = 12_500_000,
    parameter int unsigned GRID_W   = 40,
    parameter int unsigned GRID_H   = 30
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   key_up,
    input  logic                   key_down,
    input  logic                   key_left,
    input  logic                   key_right,
    input  logic                   start,
    input  logic                   add_cube,
    input  logic                   hit_stone,
    output logic [5:0]             head_x,
    output logic [5:0]             head_y,
    output logic [6*MAX_LEN-1:0]   seg_x_flat,
    output logic [6*MAX_LEN-1:0]   seg_y_flat,
    output logic [MAX_LEN-1:0]     seg_valid,
    output logic [4:0]             body_len,
    output logic [1:0]             game_state,
    output logic                   move_tick
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_DEAD = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [4:0]    LEN_MAX   = 5'(MAX_LEN);
    localparam logic [4:0]    LEN_INIT  = 5'(INIT_LEN);
    localparam logic [5:0]    X_WALL    = 6'(GRID_W - 1);
    localparam logic [5:0]    Y_WALL    = 6'(GRID_H - 1);

    state_t          state, state_nx;
    dir_t            dir, pend_dir, key_dir, dir_after;
    logic            key_any;
    logic            grow_pend;
    logic [TW-1:0]   tick_cnt;
    logic            tick_r;
    logic [4:0]      len;
    logic [5:0]      seg_x [MAX_LEN];
    logic [5:0]      seg_y [MAX_LEN];

    logic            move_due;
    logic            grow_eff;
    logic            grow_now;
    logic            wall_hit;
    logic            self_hit;
    logic            collide;
    logic            commit;
    logic            restart;
    logic [5:0]      nx, ny;

    function automatic logic is_opp(input dir_t a, input dir_t b);
        return (a == DIR_UP    && b == DIR_DOWN)  ||
               (a == DIR_DOWN  && b == DIR_UP)    ||
               (a == DIR_LEFT  && b == DIR_RIGHT) ||
               (a == DIR_RIGHT && b == DIR_LEFT);
    endfunction

    always_comb begin
        key_any = key_up | key_down | key_left | key_right;
        key_dir = DIR_RIGHT;
        if (key_up)
            key_dir = DIR_UP;
        else if (key_down)
            key_dir = DIR_DOWN;
        else if (key_left)
            key_dir = DIR_LEFT;
    end

    assign move_due = (state == S_PLAY) && (tick_cnt == TICK_LAST);
    // In a move cycle the pending direction becomes committed, so a new key
    // is screened against the direction that will hold after this edge.
    assign dir_after = move_due ? pend_dir : dir;

    always_comb begin
        nx = seg_x[0];
        ny = seg_y[0];
        case (pend_dir)
            DIR_UP:    ny = seg_y[0] - 6'd1;
            DIR_DOWN:  ny = seg_y[0] + 6'd1;
            DIR_LEFT:  nx = seg_x[0] - 6'd1;
            default:   nx = seg_x[0] + 6'd1;
        endcase
    end

    assign grow_eff = grow_pend | add_cube;
    assign grow_now = grow_eff && (len < LEN_MAX);
    assign wall_hit = (nx == 6'd0) || (nx == X_WALL) || (ny == 6'd0) || (ny == Y_WALL);

    // The tail cell is free to enter unless the body actually lengthens;
    // at saturation the tail still drops, so it vacates as normal.
    always_comb begin
        self_hit = 1'b0;
        for (int unsigned i = 1; i < MAX_LEN; i++) begin
            if (i < 32'(len) && !(i == 32'(len) - 1 && !grow_now) &&
                seg_x[i] == nx && seg_y[i] == ny)
                self_hit = 1'b1;
        end
    end

    assign collide = wall_hit | self_hit;
    assign commit  = move_due && !hit_stone && !collide;
    assign restart = (state == S_DEAD) && start;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start) state_nx = S_PLAY;
            S_PLAY: if (hit_stone || (move_due && collide)) state_nx = S_DEAD;
            S_DEAD: if (start) state_nx = S_PLAY;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            dir       <= DIR_RIGHT;
            pend_dir  <= DIR_RIGHT;
            grow_pend <= 1'b0;
            tick_cnt  <= '0;
            tick_r    <= 1'b0;
            len       <= LEN_INIT;
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                if (i < INIT_LEN) begin
                    seg_x[i] <= 6'(8 - i);
                    seg_y[i] <= 6'd27;
                end else begin
                    seg_x[i] <= '0;
                    seg_y[i] <= '0;
                end
            end
        end else begin
            tick_r <= commit;

            if (state == S_PLAY && state_nx == S_PLAY)
                tick_cnt <= move_due ? '0 : tick_cnt + 1'b1;
            else
                tick_cnt <= '0;

            if (key_any && !is_opp(key_dir, dir_after))
                pend_dir <= key_dir;

            if (state != S_PLAY || commit)
                grow_pend <= 1'b0;
            else if (add_cube)
                grow_pend <= 1'b1;

            if (commit) begin
                dir      <= pend_dir;
                seg_x[0] <= nx;
                seg_y[0] <= ny;
                for (int unsigned i = 1; i < MAX_LEN; i++) begin
                    seg_x[i] <= seg_x[i-1];
                    seg_y[i] <= seg_y[i-1];
                end
                if (grow_now)
                    len <= len + 5'd1;
            end
        end
    end

    always_comb begin
        seg_x_flat = '0;
        seg_y_flat = '0;
        seg_valid  = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            seg_x_flat[6*i +: 6] = seg_x[i];
            seg_y_flat[6*i +: 6] = seg_y[i];
            seg_valid[i]         = (i < 32'(len));
        end
    end

    assign head_x     = seg_x[0];
    assign head_y     = seg_y[0];
    assign body_len   = len;
    assign game_state = state;
    assign move_tick  = tick_r;

endmodule

// File: tb/tb_snake_body_ctrl.sv
// Directed bench for snake_body_ctrl: table of per-move vectors plus
// hand sequences for wall death, restart, stone hit and tail chasing.
module tb_snake_body_ctrl;

    localparam int unsigned ML = 16;
    localparam logic [3:0] K_N = 4'b0000;
    localparam logic [3:0] K_U = 4'b1000;
    localparam logic [3:0] K_D = 4'b0100;
    localparam logic [3:0] K_L = 4'b0010;
    localparam logic [3:0] K_R = 4'b0001;

    typedef struct {
        logic [3:0] k1;
        logic [3:0] k2;
        logic       add;
        logic       hit;
        logic [5:0] ex;
        logic [5:0] ey;
        logic [4:0] elen;
        logic [1:0] est;
        logic       etick;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
    logic start = 1'b0, add_cube = 1'b0, hit_stone = 1'b0;
    logic [5:0]        head_x, head_y;
    logic [6*ML-1:0]   seg_x_flat, seg_y_flat;
    logic [ML-1:0]     seg_valid;
    logic [4:0]        body_len;
    logic [1:0]        game_state;
    logic              move_tick;

    int checks = 0;
    int failures = 0;
    vec_t tbl[33];

    always #5 clk = ~clk;

    snake_body_ctrl #(
        .MAX_LEN(16),
        .INIT_LEN(3),
        .TICK_DIV(4),
        .GRID_W(40),
        .GRID_H(30)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_up(key_up),
        .key_down(key_down),
        .key_left(key_left),
        .key_right(key_right),
        .start(start),
        .add_cube(add_cube),
        .hit_stone(hit_stone),
        .head_x(head_x),
        .head_y(head_y),
        .seg_x_flat(seg_x_flat),
        .seg_y_flat(seg_y_flat),
        .seg_valid(seg_valid),
        .body_len(body_len),
        .game_state(game_state),
        .move_tick(move_tick)
    );

    function automatic vec_t mk(input logic [3:0] k1, input logic [3:0] k2,
                                input logic add, input logic hit,
                                input int x, input int y, input int len,
                                input int st, input logic tk);
        vec_t v;
        v.k1 = k1; v.k2 = k2; v.add = add; v.hit = hit;
        v.ex = 6'(x); v.ey = 6'(y); v.elen = 5'(len); v.est = 2'(st); v.etick = tk;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic drive_keys(input logic [3:0] m);
        {key_up, key_down, key_left, key_right} = m;
    endtask

    task automatic check_head(input string tag, input int x, input int y, input int len, input int st);
        chk($sformatf("%s.head_x", tag), 32'(head_x), 32'(x));
        chk($sformatf("%s.head_y", tag), 32'(head_y), 32'(y));
        chk($sformatf("%s.len", tag), 32'(body_len), 32'(len));
        chk($sformatf("%s.state", tag), 32'(game_state), 32'(st));
    endtask

    task automatic check_seg(input string tag, input int i, input int x, input int y);
        chk($sformatf("%s.seg%0d_x", tag, i), 32'(seg_x_flat[6*i +: 6]), 32'(x));
        chk($sformatf("%s.seg%0d_y", tag, i), 32'(seg_y_flat[6*i +: 6]), 32'(y));
    endtask

    // One move window of four clocks, entered #1 after the previous move edge.
    task automatic apply_vec(input vec_t v, input string tag);
        drive_keys(v.k1);
        add_cube = v.add;
        @(posedge clk); #1;
        add_cube = 1'b0;
        drive_keys(v.k2);
        @(posedge clk); #1;
        drive_keys(K_N);
        @(posedge clk); #1;
        chk($sformatf("%s.mt_mid", tag), 32'(move_tick), 32'd0);
        hit_stone = v.hit;
        @(posedge clk); #1;
        hit_stone = 1'b0;
        check_head(tag, int'(v.ex), int'(v.ey), int'(v.elen), int'(v.est));
        chk($sformatf("%s.move_tick", tag), 32'(move_tick), 32'(v.etick));
    endtask

    task automatic run_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++)
            apply_vec(tbl[i], $sformatf("vec%0d", i));
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        tbl[0] = mk(K_N, K_N, 0, 0,  9, 27, 3, 1, 1);
        tbl[1] = mk(K_N, K_N, 0, 0, 10, 27, 3, 1, 1);
        tbl[2] = mk(K_N, K_N, 0, 0, 11, 27, 3, 1, 1);
        tbl[3] = mk(K_N, K_N, 1, 0, 12, 27, 4, 1, 1);
        tbl[4] = mk(K_L, K_N, 0, 0, 13, 27, 4, 1, 1);
        tbl[5] = mk(K_U, K_L, 0, 0, 13, 26, 4, 1, 1);
        tbl[6] = mk(K_L, K_N, 0, 0, 12, 26, 4, 1, 1);
        tbl[7] = mk(K_U, K_N, 1, 0, 12, 25, 5, 1, 1);
        for (int i = 8; i <= 20; i++)
            tbl[i] = mk(K_N, K_N, 1, 0, 12, 32 - i, (i - 2 > 16) ? 16 : i - 2, 1, 1);
        tbl[21] = mk(K_N, K_N, 1, 0,  9, 27, 4, 1, 1);
        tbl[22] = mk(K_N, K_N, 1, 0, 10, 27, 5, 1, 1);
        tbl[23] = mk(K_U, K_N, 0, 0, 10, 26, 5, 1, 1);
        tbl[24] = mk(K_L, K_N, 0, 0,  9, 26, 5, 1, 1);
        tbl[25] = mk(K_D, K_N, 0, 0,  9, 26, 5, 2, 0);
        tbl[26] = mk(K_N, K_N, 1, 0,  9, 27, 4, 1, 1);
        tbl[27] = mk(K_U | K_R, K_N, 0, 0, 9, 26, 4, 1, 1);
        tbl[28] = mk(K_L, K_N, 0, 0,  8, 26, 4, 1, 1);
        tbl[29] = mk(K_D, K_N, 0, 0,  8, 27, 4, 1, 1);
        tbl[30] = mk(K_R, K_N, 0, 0,  9, 27, 4, 1, 1);
        tbl[31] = mk(K_U, K_N, 0, 0,  9, 26, 4, 1, 1);
        tbl[32] = mk(K_L, K_N, 0, 0,  8, 26, 4, 1, 1);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_head("reset", 8, 27, 3, 0);
        chk("reset.move_tick", 32'(move_tick), 32'd0);
        chk("reset.seg_valid", 32'(seg_valid), 32'h0007);
        check_seg("reset", 1, 7, 27);
        check_seg("reset", 2, 6, 27);
        check_seg("reset", 3, 0, 0);

        repeat (6) @(posedge clk);
        #1;
        check_head("idle_hold", 8, 27, 3, 0);

        do_start();
        check_head("start", 8, 27, 3, 1);
        run_range(0, 20);
        chk("sat.seg_valid", 32'(seg_valid), 32'h0000_FFFF);
        check_seg("sat", 14, 12, 26);
        check_seg("sat", 15, 13, 26);

        apply_vec(mk(K_R, K_N, 0, 0, 13, 12, 16, 1, 1), "turn_right");
        for (int x = 14; x <= 38; x++)
            apply_vec(mk(K_N, K_N, 0, 0, x, 12, 16, 1, 1), $sformatf("run_x%0d", x));
        apply_vec(mk(K_N, K_N, 0, 0, 38, 12, 16, 2, 0), "wall");
        repeat (8) @(posedge clk);
        #1;
        check_head("dead_frozen", 38, 12, 16, 2);
        chk("dead_frozen.move_tick", 32'(move_tick), 32'd0);

        do_start();
        check_head("restart", 8, 27, 3, 1);
        chk("restart.seg_valid", 32'(seg_valid), 32'h0007);
        check_seg("restart", 2, 6, 27);
        apply_vec(mk(K_N, K_N, 0, 0, 9, 27, 3, 1, 1), "after_restart");

        apply_vec(mk(K_N, K_N, 1, 1, 9, 27, 3, 2, 0), "stone");
        check_seg("stone", 1, 8, 27);
        check_seg("stone", 2, 7, 27);
        repeat (4) @(posedge clk);
        #1;
        check_head("stone_hold", 9, 27, 3, 2);
        chk("stone_hold.move_tick", 32'(move_tick), 32'd0);

        do_start();
        run_range(21, 25);
        do_start();
        run_range(26, 32);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
